bcd_timekeeper_alarm: RTL and testbench



---
 rtl/bcd_timekeeper_alarm.sv | 142 ++++++++++++++
 tb/tb_bcd_timekeeper_alarm.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_timekeeper_alarm.sv
// BCD HH:MM:SS.CC timekeeper with validated field loads
// and an alarm that rings until ack, disable or timeout.
module bcd_timekeeper_alarm #(
  parameter int CLK_HZ    = 50000000,
  parameter int TICK_HZ   = 100,
  parameter int RING_SECS = 60
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic [7:0]  time_in,
  input  logic [1:0]  field_sel,
  input  logic        load_time,
  input  logic        load_alarm,
  input  logic        alarm_en,
  input  logic        alarm_ack,
  output logic [31:0] time_out,
  output logic [31:0] alarm_out,
  output logic        alarm_sound,
  output logic        tick,
  output logic        load_err
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam int RW  = (RING_SECS > 0) ? $clog2(RING_SECS + 1) : 1;
  localparam logic [RW-1:0] RLIM = RW'(RING_SECS);

  typedef enum logic {IDLE, RINGING} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [RW-1:0] ring_cnt;

  logic        tick_cyc;
  logic        valid;
  logic [7:0]  lim;
  logic        ld_t_ok;
  logic        ld_a_ok;
  logic        ld_bad;
  logic        inc_en;
  logic        c_cc, c_ss, c_mm, c_hh;
  logic [7:0]  n_cc, n_ss, n_mm, n_hh;
  logic [31:0] time_nx;
  logic        match;

  // Returns {carry, next} for a two-digit BCD field wrapping at top.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v,
                                         input logic [7:0] top);
    if (v == top) return 9'h100;
    if (v[3:0] == 4'd9) return {1'b0, v[7:4] + 4'd1, 4'd0};
    return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  // Per-field upper bound and load validation.
  always_comb begin
    lim = 8'h99;
    unique case (field_sel)
      2'd0: lim = 8'h99;
      2'd1: lim = 8'h59;
      2'd2: lim = 8'h59;
      2'd3: lim = 8'h23;
    endcase
    valid   = (time_in[7:4] <= 4'd9) && (time_in[3:0] <= 4'd9) &&
              (time_in <= lim);
    ld_t_ok = load_time && valid;
    ld_a_ok = load_alarm && valid;
    ld_bad  = (load_time || load_alarm) && !valid;
  end

  assign tick_cyc = (presc == PMAX);
  assign inc_en   = tick_cyc && !ld_t_ok;

  // BCD cascade CC -> SS -> MM -> HH.
  always_comb begin
    {c_cc, n_cc} = bcd_inc(time_out[7:0], 8'h99);
    {c_ss, n_ss} = c_cc ? bcd_inc(time_out[15:8], 8'h59)
                        : {1'b0, time_out[15:8]};
    {c_mm, n_mm} = c_ss ? bcd_inc(time_out[23:16], 8'h59)
                        : {1'b0, time_out[23:16]};
    {c_hh, n_hh} = c_mm ? bcd_inc(time_out[31:24], 8'h23)
                        : {1'b0, time_out[31:24]};
    time_nx = {n_hh, n_mm, n_ss, n_cc};
  end

  assign match = alarm_en && inc_en && c_cc &&
                 (time_nx[31:8] == alarm_out[31:8]);

  // Prescaler, time/alarm registers, tick and load_err pulses.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      presc     <= '0;
      time_out  <= '0;
      alarm_out <= '0;
      tick      <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      tick     <= inc_en;
      load_err <= ld_bad;
      if (ld_t_ok || tick_cyc) presc <= '0;
      else presc <= presc + 1'b1;
      if (ld_t_ok) time_out[{field_sel, 3'b000} +: 8] <= time_in;
      else if (inc_en) time_out <= time_nx;
      if (ld_a_ok) alarm_out[{field_sel, 3'b000} +: 8] <= time_in;
    end
  end

  // Alarm FSM with registered sound output and ring-seconds counter.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      alarm_sound <= 1'b0;
      ring_cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          ring_cnt <= '0;
          if (match) begin
            state       <= RINGING;
            alarm_sound <= 1'b1;
          end
        end
        RINGING: begin
          if (alarm_ack || !alarm_en) begin
            state       <= IDLE;
            alarm_sound <= 1'b0;
            ring_cnt    <= '0;
          end else if (RING_SECS != 0 && inc_en && c_cc) begin
            if (ring_cnt + 1'b1 == RLIM) begin
              state       <= IDLE;
              alarm_sound <= 1'b0;
              ring_cnt    <= '0;
            end else begin
              ring_cnt <= ring_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_timekeeper_alarm.sv
// Directed bench for bcd_timekeeper_alarm:
// load table, rollover, collision, alarm ack/timeout/reset.
module tb_bcd_timekeeper_alarm;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  time_in = '0;
  logic [1:0]  field_sel = '0;
  logic        load_time = 1'b0;
  logic        load_alarm = 1'b0;
  logic        alarm_en = 1'b0;
  logic        alarm_ack = 1'b0;
  logic [31:0] time_out;
  logic [31:0] alarm_out;
  logic        alarm_sound;
  logic        tick;
  logic        load_err;

  int checks = 0;
  int errors = 0;

  bcd_timekeeper_alarm #(
    .CLK_HZ(1000), .TICK_HZ(100), .RING_SECS(3)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .time_in(time_in),
    .field_sel(field_sel), .load_time(load_time),
    .load_alarm(load_alarm), .alarm_en(alarm_en),
    .alarm_ack(alarm_ack), .time_out(time_out),
    .alarm_out(alarm_out), .alarm_sound(alarm_sound),
    .tick(tick), .load_err(load_err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic        lt;
    logic        la;
    logic [1:0]  sel;
    logic [7:0]  val;
    logic        err;
    logic [31:0] t;
    logic [31:0] a;
  } vec_t;

  vec_t v[11];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge CLOCK_50);
  endtask

  task automatic ld(input logic lt, input logic la,
                    input logic [1:0] sel, input logic [7:0] val);
    load_time  = lt;
    load_alarm = la;
    field_sel  = sel;
    time_in    = val;
    cyc();
    load_time  = 1'b0;
    load_alarm = 1'b0;
  endtask

  task automatic set_time(input logic [7:0] hh, input logic [7:0] mm,
                          input logic [7:0] ss, input logic [7:0] cc);
    ld(1, 0, 2'd3, hh);
    ld(1, 0, 2'd2, mm);
    ld(1, 0, 2'd1, ss);
    ld(1, 0, 2'd0, cc);
  endtask

  task automatic ring_start(input string name);
    int early;
    early = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (k < 10 && alarm_sound) early++;
    end
    chk({name, "_early"}, early, 0);
    chk({name, "_sound"}, {31'd0, alarm_sound}, 1);
    chk({name, "_time"}, time_out, 32'h07300000);
  endtask

  initial begin
    int tcnt;
    int hi;
    int n;

    v[0]  = '{1, 0, 2'd3, 8'h23, 0, 32'h23000000, 32'h00000000};
    v[1]  = '{1, 0, 2'd2, 8'h59, 0, 32'h23590000, 32'h00000000};
    v[2]  = '{1, 0, 2'd1, 8'h59, 0, 32'h23595900, 32'h00000000};
    v[3]  = '{1, 0, 2'd0, 8'h99, 0, 32'h23595999, 32'h00000000};
    v[4]  = '{1, 0, 2'd1, 8'h60, 1, 32'h23595999, 32'h00000000};
    v[5]  = '{1, 0, 2'd0, 8'h1A, 1, 32'h23595999, 32'h00000000};
    v[6]  = '{1, 0, 2'd3, 8'h24, 1, 32'h23595999, 32'h00000000};
    v[7]  = '{0, 1, 2'd3, 8'h07, 0, 32'h23595999, 32'h07000000};
    v[8]  = '{0, 1, 2'd2, 8'h30, 0, 32'h23595999, 32'h07300000};
    v[9]  = '{0, 1, 2'd1, 8'h60, 1, 32'h23595999, 32'h07300000};
    v[10] = '{1, 1, 2'd3, 8'hA0, 1, 32'h23595999, 32'h07300000};

    repeat (3) cyc();
    chk("rst_time", time_out, 0);
    chk("rst_alarm", alarm_out, 0);
    chk("rst_sound", {31'd0, alarm_sound}, 0);
    chk("rst_tick", {31'd0, tick}, 0);
    chk("rst_err", {31'd0, load_err}, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      ld(v[i].lt, v[i].la, v[i].sel, v[i].val);
      chk($sformatf("vec%0d_err", i), {31'd0, load_err}, {31'd0, v[i].err});
      chk($sformatf("vec%0d_time", i), time_out, v[i].t);
      chk($sformatf("vec%0d_alarm", i), alarm_out, v[i].a);
      chk($sformatf("vec%0d_tick", i), {31'd0, tick}, 0);
    end

    // Rollover 23:59:59.99 -> 00:00:00.00 ten cycles after a load
    ld(1, 0, 2'd0, 8'h99);
    tcnt = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (tick) tcnt++;
    end
    chk("roll_time", time_out, 32'h00000000);
    chk("roll_tick", {31'd0, tick}, 1);
    chk("roll_tcnt", tcnt, 1);
    cyc();
    chk("roll_tick_off", {31'd0, tick}, 0);

    // Load on the tick cycle wins and drops the increment
    ld(1, 0, 2'd0, 8'h10);
    tcnt = 0;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      if (tick) tcnt++;
    end
    chk("coll_pre_ticks", tcnt, 0);
    ld(1, 0, 2'd0, 8'h42);
    chk("coll_cc", {24'd0, time_out[7:0]}, 32'h42);
    chk("coll_tick", {31'd0, tick}, 0);
    tcnt = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (k < 10 && tick) tcnt++;
    end
    chk("coll_early", tcnt, 0);
    chk("coll_next_tick", {31'd0, tick}, 1);
    chk("coll_next_cc", {24'd0, time_out[7:0]}, 32'h43);

    // Alarm trigger then acknowledge
    ld(0, 1, 2'd1, 8'h00);
    ld(0, 1, 2'd0, 8'h00);
    chk("alm_set", alarm_out, 32'h07300000);
    alarm_en = 1'b1;
    set_time(8'h07, 8'h29, 8'h59, 8'h99);
    ring_start("ack");
    repeat (4) cyc();
    chk("ack_still", {31'd0, alarm_sound}, 1);
    alarm_ack = 1'b1;
    cyc();
    alarm_ack = 1'b0;
    chk("ack_off", {31'd0, alarm_sound}, 0);
    hi = 0;
    for (int k = 0; k < 300; k++) begin
      cyc();
      if (alarm_sound) hi++;
    end
    chk("ack_noretrig", hi, 0);

    // Auto-silence after three counted seconds
    set_time(8'h07, 8'h29, 8'h59, 8'h99);
    ring_start("to");
    n = 0;
    while (alarm_sound && n < 4000) begin
      cyc();
      n++;
    end
    chk("to_cycles", n, 3000);
    chk("to_time", time_out, 32'h07300300);

    // Disabling mid-ring silences next cycle
    set_time(8'h07, 8'h29, 8'h59, 8'h99);
    ring_start("en");
    repeat (3) cyc();
    alarm_en = 1'b0;
    cyc();
    chk("en_off", {31'd0, alarm_sound}, 0);
    alarm_en = 1'b1;

    // Asynchronous reset while ringing
    set_time(8'h07, 8'h29, 8'h59, 8'h99);
    ring_start("rst");
    #2 reset_n = 1'b0;
    #1;
    chk("rst_ring_sound", {31'd0, alarm_sound}, 0);
    chk("rst_ring_time", time_out, 0);
    chk("rst_ring_alarm", alarm_out, 0);
    cyc();
    reset_n = 1'b1;
    tcnt = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (k < 10 && tick) tcnt++;
    end
    chk("rst_early", tcnt, 0);
    chk("rst_first_tick", {31'd0, tick}, 1);
    chk("rst_first_time", time_out, 32'h00000001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
